// File: rtl/diff_demo_pkg.sv
// Shared types and constants for the feature-map / guard loader.
//   ld_state_e   : loader FSM states (idle, streaming, one-cycle done)
//   LD_SEL_FM/GD : command target select encodings
//   FM_BITS      : feature-map entry width per column
//   GD_BITS      : guard entry width per column
package diff_demo_pkg;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;

  localparam logic LD_SEL_FM = 1'b0;
  localparam logic LD_SEL_GD = 1'b1;

  localparam int FM_BITS = 8;
  localparam int GD_BITS = 6;

endpackage

// File: rtl/fm_gd_loader.sv
// fm_gd_loader: drains the DMA MM2S stream under a controller command and
// scatters each 64-bit beat across the PE columns as feature-map (8-bit) or
// guard (6-bit) buffer writes.
//   clk, rst_n              : clock, async active-low reset
//   cmd_*                   : command (target, bank, base address, beat count)
//   m_axis_mm2s_*           : input AXI-Stream beats
//   load_fm_* / load_gd_*   : per-column buffer write ports (registered)
//   done / err              : completion pulse / framing error (held)
module fm_gd_loader
  import diff_demo_pkg::*;
#(
  parameter int PE_COL         = 8,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int FM_BUF_DEPTH   = 1024,
  parameter int GD_BUF_DEPTH   = 256,
  parameter int LEN_WIDTH      = 16,
  localparam int FM_AW         = $clog2(FM_BUF_DEPTH),
  localparam int GD_AW         = $clog2(GD_BUF_DEPTH),
  localparam int KEEP_W        = DDR_DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_sel,
  input  logic                             cmd_ping_pong,
  input  logic [FM_AW-1:0]                 cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]             cmd_len,
  input  logic [DDR_DATA_WIDTH-1:0]        m_axis_mm2s_tdata,
  input  logic [KEEP_W-1:0]                m_axis_mm2s_tkeep,
  input  logic                             m_axis_mm2s_tlast,
  input  logic                             m_axis_mm2s_tvalid,
  output logic                             m_axis_mm2s_tready,
  output logic [PE_COL-1:0][FM_AW-1:0]     load_fm_wr_addr,
  output logic [PE_COL-1:0][FM_BITS-1:0]   load_fm_din,
  output logic [PE_COL-1:0]                load_fm_wr_en,
  output logic [PE_COL-1:0]                load_fm_ping_pong,
  output logic [PE_COL-1:0][GD_AW-1:0]     load_gd_wr_addr,
  output logic [PE_COL-1:0][GD_BITS-1:0]   load_gd_din,
  output logic [PE_COL-1:0]                load_gd_wr_en,
  output logic [PE_COL-1:0]                load_gd_ping_pong,
  output logic                             done,
  output logic                             err
);

  ld_state_e             state_q, state_d;
  logic                  sel_q, pp_q, err_q;
  logic [FM_AW-1:0]      base_q;
  logic [LEN_WIDTH-1:0]  len_q, cnt_q;
  // Handshake outputs are registered copies of "next state is X" so that
  // they read 0 while reset is held and match the state once running.
  logic                  cmd_rdy_q, tready_q;

  logic                  cmd_fire, beat, last_cnt, beat_end;
  logic [FM_AW-1:0]      addr_nxt;

  logic [PE_COL-1:0][FM_AW-1:0]   fm_addr_nxt, fm_addr_q;
  logic [PE_COL-1:0][FM_BITS-1:0] fm_din_nxt, fm_din_q;
  logic [PE_COL-1:0][GD_AW-1:0]   gd_addr_nxt, gd_addr_q;
  logic [PE_COL-1:0][GD_BITS-1:0] gd_din_nxt, gd_din_q;
  logic [PE_COL-1:0]              fm_wen_q, gd_wen_q;

  assign cmd_fire = cmd_valid && cmd_rdy_q;
  assign beat     = m_axis_mm2s_tvalid && tready_q;
  assign last_cnt = (cnt_q == len_q - LEN_WIDTH'(1));
  assign beat_end = beat && (last_cnt || m_axis_mm2s_tlast);

  // Buffer address wraps modulo the depth by plain truncation.
  assign addr_nxt = base_q + FM_AW'(cnt_q);

  // Beat unpacker: byte lanes for FM, packed 6-bit fields for guard.
  for (genvar c = 0; c < PE_COL; c++) begin : g_col
    assign fm_din_nxt[c]  = m_axis_mm2s_tdata[c*FM_BITS +: FM_BITS];
    assign gd_din_nxt[c]  = m_axis_mm2s_tdata[c*GD_BITS +: GD_BITS];
    assign fm_addr_nxt[c] = addr_nxt;
    assign gd_addr_nxt[c] = addr_nxt[GD_AW-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE: if (cmd_fire) state_d = (cmd_len == '0) ? LD_DONE : LD_LOAD;
      LD_LOAD: if (beat_end) state_d = LD_DONE;
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LD_IDLE;
      cmd_rdy_q <= 1'b0;
      tready_q  <= 1'b0;
      sel_q     <= LD_SEL_FM;
      pp_q      <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      fm_addr_q <= '0;
      fm_din_q  <= '0;
      gd_addr_q <= '0;
      gd_din_q  <= '0;
      fm_wen_q  <= '0;
      gd_wen_q  <= '0;
    end else begin
      state_q   <= state_d;
      cmd_rdy_q <= (state_d == LD_IDLE);
      tready_q  <= (state_d == LD_LOAD);
      if (cmd_fire) begin
        sel_q  <= cmd_sel;
        pp_q   <= cmd_ping_pong;
        base_q <= cmd_base_addr;
        len_q  <= cmd_len;
        cnt_q  <= '0;
        err_q  <= 1'b0;
      end else if (beat) begin
        cnt_q <= cnt_q + LEN_WIDTH'(1);
        // Clean end only when the counted last beat also carries tlast.
        if (beat_end) err_q <= !(last_cnt && m_axis_mm2s_tlast);
      end
      if (beat) begin
        fm_addr_q <= fm_addr_nxt;
        fm_din_q  <= fm_din_nxt;
        gd_addr_q <= gd_addr_nxt;
        gd_din_q  <= gd_din_nxt;
      end
      fm_wen_q <= (beat && sel_q == LD_SEL_FM) ? m_axis_mm2s_tkeep : '0;
      gd_wen_q <= (beat && sel_q == LD_SEL_GD) ? {PE_COL{|m_axis_mm2s_tkeep}} : '0;
    end
  end

  assign cmd_ready          = cmd_rdy_q;
  assign m_axis_mm2s_tready = tready_q;
  assign load_fm_wr_addr    = fm_addr_q;
  assign load_fm_din        = fm_din_q;
  assign load_fm_wr_en      = fm_wen_q;
  assign load_fm_ping_pong  = {PE_COL{pp_q}};
  assign load_gd_wr_addr    = gd_addr_q;
  assign load_gd_din        = gd_din_q;
  assign load_gd_wr_en      = gd_wen_q;
  assign load_gd_ping_pong  = {PE_COL{pp_q}};
  assign done               = (state_q == LD_DONE);
  assign err                = err_q;

endmodule

// File: tb/tb_fm_gd_loader.sv
module tb_fm_gd_loader;
  import diff_demo_pkg::*;

  localparam int PE_COL = 8;
  localparam int DW     = 64;
  localparam int FMD    = 1024;
  localparam int GDD    = 256;
  localparam int LW     = 16;
  localparam int FAW    = 10;
  localparam int GAW    = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                         cmd_valid, cmd_ready, cmd_sel, cmd_ping_pong;
  logic [FAW-1:0]               cmd_base_addr;
  logic [LW-1:0]                cmd_len;
  logic [DW-1:0]                tdata;
  logic [7:0]                   tkeep;
  logic                         tlast, tvalid, tready;
  logic [PE_COL-1:0][FAW-1:0]   fm_addr;
  logic [PE_COL-1:0][7:0]       fm_din;
  logic [PE_COL-1:0]            fm_en, fm_pp;
  logic [PE_COL-1:0][GAW-1:0]   gd_addr;
  logic [PE_COL-1:0][5:0]       gd_din;
  logic [PE_COL-1:0]            gd_en, gd_pp;
  logic                         done, err;

  fm_gd_loader dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_ping_pong(cmd_ping_pong), .cmd_base_addr(cmd_base_addr), .cmd_len(cmd_len),
    .m_axis_mm2s_tdata(tdata), .m_axis_mm2s_tkeep(tkeep), .m_axis_mm2s_tlast(tlast),
    .m_axis_mm2s_tvalid(tvalid), .m_axis_mm2s_tready(tready),
    .load_fm_wr_addr(fm_addr), .load_fm_din(fm_din), .load_fm_wr_en(fm_en),
    .load_fm_ping_pong(fm_pp),
    .load_gd_wr_addr(gd_addr), .load_gd_din(gd_din), .load_gd_wr_en(gd_en),
    .load_gd_ping_pong(gd_pp),
    .done(done), .err(err)
  );

  typedef struct {
    logic        sel;
    logic [7:0]  wen;
    logic [9:0]  addr;
    logic [63:0] data;
    logic        pp;
  } wr_t;

  typedef struct {
    logic err;
    logic wr_same;
    logic pp;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  int  total = 0;
  int  bad   = 0;
  int  done_cnt = 0;

  task automatic chk(input string name, input logic ok, input string msg);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL %s: %s", name, msg);
    end
  endtask

  function automatic logic outs_zero();
    return (cmd_ready | tready | (|fm_addr) | (|fm_din) | (|fm_en) | (|fm_pp) |
            (|gd_addr) | (|gd_din) | (|gd_en) | (|gd_pp) | done | err) == 1'b0;
  endfunction

  // Monitor: pops expected writes / completions whenever the DUT shows one.
  always @(negedge clk) begin
    wr_t e;
    dn_t d;
    logic [PE_COL-1:0][FAW-1:0] ea;
    logic [PE_COL-1:0][7:0]     ed;
    logic [PE_COL-1:0][GAW-1:0] ga;
    logic [PE_COL-1:0][5:0]     gdd;
    logic ok;
    if (rst_n) begin
      if ((|fm_en) || (|gd_en)) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 1'b0,
              $sformatf("got fm_en=%h gd_en=%h, expected no write", fm_en, gd_en));
        end else begin
          e = wq.pop_front();
          for (int c = 0; c < PE_COL; c++) begin
            ea[c]  = e.addr;
            ed[c]  = e.data[c*8 +: 8];
            ga[c]  = e.addr[GAW-1:0];
            gdd[c] = e.data[c*6 +: 6];
          end
          if (e.sel == LD_SEL_FM)
            ok = (fm_en == e.wen) && (gd_en == '0) && (fm_addr == ea) &&
                 (fm_din == ed) && (fm_pp == {PE_COL{e.pp}});
          else
            ok = (gd_en == e.wen) && (fm_en == '0) && (gd_addr == ga) &&
                 (gd_din == gdd) && (gd_pp == {PE_COL{e.pp}});
          chk(e.sel ? "gd_write" : "fm_write", ok,
              $sformatf("got fm_en=%h gd_en=%h fm_addr0=%h gd_addr0=%h fm_din=%h gd_din=%h pp=%h; expected en=%h addr=%h data=%h pp=%0d",
                        fm_en, gd_en, fm_addr[0], gd_addr[0], fm_din, gd_din, fm_pp,
                        e.wen, e.addr, e.data, e.pp));
        end
      end
      if (done) begin
        done_cnt++;
        if (dq.size() == 0) begin
          chk("unexpected_done", 1'b0, "got done=1, expected none");
        end else begin
          d = dq.pop_front();
          ok = (err == d.err) && (((|fm_en) || (|gd_en)) == d.wr_same) &&
               (fm_pp == {PE_COL{d.pp}}) && (gd_pp == {PE_COL{d.pp}});
          chk("done", ok,
              $sformatf("got err=%0d write_same_cycle=%0d pp=%h; expected err=%0d write_same_cycle=%0d pp=%0d",
                        err, (|fm_en) || (|gd_en), fm_pp, d.err, d.wr_same, d.pp));
        end
      end
    end
  end

  // Issue one command, offer its beats (tlast at last_idx, -1/out of range =
  // never), push the reference-model expectations, and wait for completion.
  task automatic run_cmd(input logic sel, input logic pp, input logic [9:0] base,
                         input int len, input int last_idx, input logic [7:0] keep,
                         input int gap, input int stray, input bit pat);
    logic [63:0] bd[$];
    logic [7:0]  bk[$];
    bit          bl[$];
    int          k, idx, cyc, tgt;
    logic        e_err, ws, v;
    wr_t         w;
    dn_t         d;
    for (int i = 0; i < len; i++) begin
      bd.push_back(pat ? 64'h0706050403020100 + 64'(i) : {$urandom, $urandom});
      bk.push_back(keep != 0 ? keep : 8'($urandom_range(1, 255)));
      bl.push_back(i == last_idx);
    end
    // Reference: transfer stops at the first tlast or at beat len-1.
    k = len - 1;
    for (int i = 0; i < len; i++) if (bl[i]) begin k = i; break; end
    e_err = 1'b0;
    ws    = 1'b0;
    if (len > 0) begin
      e_err = !(k == len - 1 && bl[k]);
      ws    = (bk[k] != 0);
    end
    for (int i = 0; i <= k; i++) begin
      if (bk[i] != 0) begin
        w.sel  = sel;
        w.wen  = (sel == LD_SEL_GD) ? 8'hFF : bk[i];
        w.addr = 10'((int'(base) + i) % (sel == LD_SEL_GD ? GDD : FMD));
        w.data = bd[i];
        w.pp   = pp;
        wq.push_back(w);
      end
    end
    d.err = e_err; d.wr_same = ws; d.pp = pp;
    dq.push_back(d);
    tgt = done_cnt + 1;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = sel; cmd_ping_pong = pp;
    cmd_base_addr = base; cmd_len = LW'(len);
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; end
    if (!cmd_ready) begin
      chk("cmd_accept", 1'b0, "cmd_ready stayed 0, expected 1 within 50 cycles");
      cmd_valid = 1'b0; wq.delete(); dq.delete();
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    idx = 0; cyc = 0;
    while (idx <= k && cyc < 400) begin
      v = ($urandom_range(0, 99) >= gap);
      tvalid = v;
      tdata  = v ? bd[idx] : {$urandom, $urandom};
      tkeep  = bk[idx];
      tlast  = bl[idx];
      if (v && tready) idx++;
      cyc++;
      @(negedge clk);
    end
    tvalid = 1'b0; tlast = 1'b0;
    if (idx <= k) chk("beat_timeout", 1'b0, $sformatf("accepted %0d beats, expected %0d", idx, k + 1));
    #1;
    cyc = 0;
    while (done_cnt < tgt && cyc < 50) begin @(negedge clk); #1; cyc++; end
    chk("done_seen", done_cnt >= tgt, $sformatf("done count %0d, expected %0d", done_cnt, tgt));
    @(negedge clk);
    chk("ready_after_done", cmd_ready == 1'b1, $sformatf("cmd_ready=%0d, expected 1", cmd_ready));
    // Stray beats outside LOAD must not be consumed (monitor flags any write).
    for (int s = 0; s < stray; s++) begin
      tvalid = 1'b1; tdata = {$urandom, $urandom}; tkeep = 8'hFF; tlast = 1'b1;
      @(negedge clk);
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int   idx, cyc, dc;
    wr_t  w;
    logic [63:0] rb[2];
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_sel = 1'b0; cmd_ping_pong = 1'b0;
    cmd_base_addr = '0; cmd_len = '0;
    tdata = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_zero(), "some output nonzero during reset, expected all 0");
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", cmd_ready == 1'b1 && tready == 1'b0,
        $sformatf("cmd_ready=%0d tready=%0d, expected 1/0", cmd_ready, tready));

    // FM basic, patterned data
    run_cmd(LD_SEL_FM, 1'b1, 10'h010, 4, 3, 8'hFF, 0, 0, 1'b1);
    // Guard with address wrap at 256
    run_cmd(LD_SEL_GD, 1'b0, 10'h0FE, 3, 2, 8'hFF, 0, 0, 1'b0);
    // FM with 50% tvalid gaps
    run_cmd(LD_SEL_FM, 1'b0, 10'($urandom), 8, 7, 8'hFF, 50, 0, 1'b0);
    // Early tlast on beat 1 of 5
    run_cmd(LD_SEL_FM, 1'b1, 10'h020, 5, 1, 8'hFF, 0, 0, 1'b0);
    // Partial byte enables
    run_cmd(LD_SEL_FM, 1'b0, 10'h030, 3, 2, 8'h0F, 0, 0, 1'b0);
    // Zero-length command
    run_cmd(LD_SEL_FM, 1'b1, 10'h040, 0, -1, 8'hFF, 0, 0, 1'b0);
    // Missing tlast, stray beats afterwards; FM wrap at 1024
    run_cmd(LD_SEL_FM, 1'b0, 10'h3FE, 4, -1, 8'hFF, 0, 3, 1'b0);

    // Reset during LOAD after two beats
    dc = done_cnt;
    rb[0] = {$urandom, $urandom};
    rb[1] = {$urandom, $urandom};
    for (int i = 0; i < 2; i++) begin
      w.sel = LD_SEL_FM; w.wen = 8'hFF; w.addr = 10'(10'h100 + i);
      w.data = rb[i]; w.pp = 1'b1;
      wq.push_back(w);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = LD_SEL_FM; cmd_ping_pong = 1'b1;
    cmd_base_addr = 10'h100; cmd_len = LW'(6);
    @(negedge clk);
    cmd_valid = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 2 && cyc < 20) begin
      tvalid = 1'b1; tdata = rb[idx]; tkeep = 8'hFF; tlast = 1'b0;
      if (tready) idx++;
      cyc++;
      @(negedge clk);
    end
    tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_abort_outputs", outs_zero(), "some output nonzero after mid-load reset, expected all 0");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_abort_state", done_cnt == dc && wq.size() == 0 && cmd_ready == 1'b1,
        $sformatf("done_count=%0d pending_writes=%0d cmd_ready=%0d, expected %0d/0/1",
                  done_cnt, wq.size(), cmd_ready, dc));
    run_cmd(LD_SEL_GD, 1'b1, 10'h155, 4, 3, 8'hFF, 0, 0, 1'b0);

    // Randomized commands
    for (int n = 0; n < 12; n++) begin
      int len;
      len = $urandom_range(1, 10);
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom),
              len, $urandom_range(0, len + 1), 8'h00, $urandom_range(0, 60),
              $urandom_range(0, 2), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("queues_empty", wq.size() == 0 && dq.size() == 0,
        $sformatf("pending writes=%0d dones=%0d, expected 0/0", wq.size(), dq.size()));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
